// File: rtl/rvvi_host_ack_rx.sv
// ---------------------------------------------------------------------------
// rvvi_host_ack_rx
//
// Receive-side parser for acknowledgement frames returned by the host over
// Ethernet. It walks the 32-bit MAC RX stream one word at a time, checks the
// destination MAC and EtherType, and extracts the 16-bit frame count. Each
// qualified ack produces a single-cycle HostInstrValid pulse that carries
// HostFrameCount. Both outputs drive the rvvi active-list ack port directly.
// Every frame that is discarded increments a saturating drop counter.
//
// Ports
//   clk             clock
//   reset           synchronous, active-high reset
//   RxData [31:0]   stream word; byte lane 0 (bits[7:0]) is first on the wire
//   RxValid         RxData is valid this cycle
//   RxLast          last word of the frame (qualified by RxValid)
//   RxError         MAC error for the frame (used only with RxValid & RxLast)
//   RxReady         tied high; the parser never backpressures
//   HostInstrValid  one-cycle pulse: an ack was accepted
//   HostFrameCount  frame count of the most recent accepted ack
//   DropCount       saturating count of discarded frames
// ---------------------------------------------------------------------------
module rvvi_host_ack_rx #(
  parameter int unsigned          FRAME_COUNT_WIDTH = 16,
  parameter int unsigned          DROP_CNT_WIDTH    = 16,
  parameter logic [47:0]          LOCAL_MAC         = 48'h0000_0000_0000,
  parameter logic [15:0]          ACK_ETHERTYPE     = 16'h005c
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [31:0]                  RxData,
  input  logic                         RxValid,
  input  logic                         RxLast,
  input  logic                         RxError,
  output logic                         RxReady,
  output logic                         HostInstrValid,
  output logic [FRAME_COUNT_WIDTH-1:0] HostFrameCount,
  output logic [DROP_CNT_WIDTH-1:0]    DropCount
);

  // Word position within the current frame. TAIL skips the payload of a
  // frame whose header is complete; DROP skips a frame already rejected.
  typedef enum logic [2:0] {
    HDR0 = 3'd0,
    HDR1 = 3'd1,
    HDR2 = 3'd2,
    HDR3 = 3'd3,
    TAIL = 3'd4,
    DROP = 3'd5
  } state_t;

  state_t                       state;
  state_t                       nextState;

  logic                         matchQ;       // sticky header match for this frame
  logic [FRAME_COUNT_WIDTH-1:0] pendingQ;     // frame count captured in HDR3

  logic                         wordMatch;    // header compare of the current word
  logic                         matchNow;     // match flag including this word
  logic [FRAME_COUNT_WIDTH-1:0] pendingNow;   // pending count including this word
  logic                         reachedHdr3;  // frame is long enough to be an ack
  logic                         commit;       // RxLast word is being consumed
  logic                         accept;
  logic                         dropFrame;

  assign RxReady = 1'b1;

  // -------------------------------------------------------------------------
  // Header field compares on the current word
  // -------------------------------------------------------------------------
  // NOTE: every variable assigned in an always_comb gets a default first, so
  // no path through the case can leave it unassigned and infer a latch.
  always_comb begin
    wordMatch  = 1'b1;
    pendingNow = pendingQ;
    unique case (state)
      HDR0: wordMatch = (RxData == LOCAL_MAC[31:0]);
      HDR1: wordMatch = (RxData[15:0] == LOCAL_MAC[47:32]);
      HDR3: begin
        // Byte 12 (lane 0) is the EtherType MSB; byte 14 (lane 2) is the
        // frame-count MSB.
        wordMatch  = ({RxData[7:0], RxData[15:8]} == ACK_ETHERTYPE);
        pendingNow = FRAME_COUNT_WIDTH'({RxData[23:16], RxData[31:24]});
      end
      default: wordMatch = 1'b1;
    endcase
    // w0 starts a new frame, so the previous frame's flag is discarded there.
    matchNow = (state == HDR0) ? wordMatch : (matchQ & wordMatch);
  end

  // -------------------------------------------------------------------------
  // FSM: state register
  // -------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the pre-edge values regardless of block evaluation order.
  always_ff @(posedge clk) begin
    if (reset) state <= HDR0;
    else       state <= nextState;
  end

  // -------------------------------------------------------------------------
  // FSM: next state (advances only on valid words)
  // -------------------------------------------------------------------------
  always_comb begin
    nextState = state;
    if (RxValid) begin
      unique case (state)
        HDR0: begin
          if (RxLast)          nextState = HDR0;
          else if (!wordMatch) nextState = DROP;
          else                 nextState = HDR1;
        end
        HDR1:    nextState = RxLast ? HDR0 : HDR2;
        HDR2:    nextState = RxLast ? HDR0 : HDR3;
        HDR3:    nextState = RxLast ? HDR0 : TAIL;
        TAIL:    nextState = RxLast ? HDR0 : TAIL;
        DROP:    nextState = RxLast ? HDR0 : DROP;
        default: nextState = HDR0;
      endcase
    end
  end

  // -------------------------------------------------------------------------
  // FSM: frame commit decisions on the RxLast word
  // -------------------------------------------------------------------------
  always_comb begin
    reachedHdr3 = (state == HDR3) || (state == TAIL);
    commit      = RxValid && RxLast;
    accept      = commit && !RxError && matchNow && reachedHdr3;
    dropFrame   = commit && !accept;
  end

  // -------------------------------------------------------------------------
  // Per-frame header state: held while RxValid is low
  // -------------------------------------------------------------------------
  // NOTE: pendingQ is reset even though it is always rewritten in HDR3 before
  // it can be used; this keeps it out of X in simulation at trivial cost.
  always_ff @(posedge clk) begin
    if (reset) begin
      matchQ   <= 1'b0;
      pendingQ <= '0;
    end else if (RxValid) begin
      matchQ   <= matchNow;
      pendingQ <= pendingNow;
    end
  end

  // -------------------------------------------------------------------------
  // Ack outputs and drop counter
  // -------------------------------------------------------------------------
  // A synchronous reset on the same edge as the RxLast word also cancels the
  // pulse that word would have produced.
  always_ff @(posedge clk) begin
    if (reset) begin
      HostInstrValid <= 1'b0;
      HostFrameCount <= '0;
      DropCount      <= '0;
    end else begin
      HostInstrValid <= accept;
      if (accept) HostFrameCount <= pendingNow;
      if (dropFrame && (DropCount != '1)) DropCount <= DropCount + 1'b1;
    end
  end

endmodule
